mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port unified program/data memory between the fetch unit and the load/store unit.
//  - Turns two req/ack requesters into one CS/WE/select access per transaction.
//  - Sequences the memory's 1-cycle registered read latency.
//  - Returns each requester's data or error with an ack pulse.
//  - Sits between the core pipeline and the memory module; the core never drives memory controls directly.
// PARAMETERS
//  ADDR_BITS        `ADDR_BITS         address width, both requesters and memory
//  DATA_BITS        `DATA_BITS         store data width
//  INST_BITS        `INSTRUCTION_SIZE  memory word / fetch width
//  ROM_SIZE         `ROM_SIZE          first writable address; lower addresses are read-only
// PORTS
//  CLK          in   1          clock
//  RESET        in   1          synchronous, active-high
//  f_req        in   1          fetch request; held until f_ack
//  f_pc         in   ADDR_BITS  fetch address; stable while f_req
//  f_ack        out  1          1-cycle pulse; f_inst valid in same cycle
//  f_inst       out  INST_BITS  fetched word
//  d_req        in   1          data request; held until d_ack
//  d_we         in   1          1=store, 0=load; stable while d_req
//  d_addr       in   ADDR_BITS  data address
//  d_wdata      in   DATA_BITS  store data
//  d_ack        out  1          1-cycle pulse; d_rdata/d_err valid in same cycle
//  d_rdata      out  INST_BITS  load data
//  d_err        out  1          store to address < ROM_SIZE
//  m_cs         out  1          memory chip select
//  m_we         out  1          memory write enable
//  m_sel        out  1          0=fetch path (uses m_pc), 1=data path (uses m_addr)
//  m_pc         out  ADDR_BITS  to memory program-counter port
//  m_addr       out  ADDR_BITS  to memory data-address port
//  m_wdata      out  DATA_BITS  to memory write-data port
//  m_inst       in   INST_BITS  memory instruction output
//  m_dat        in   INST_BITS  memory data output
//  m_error      in   1          memory error flag
// BEHAVIOUR
//  - Reset: all outputs 0; FSM returns to IDLE; grant pointer set to DATA. Reset mid-transaction abandons it with no ack.
//  - FSM states: IDLE -> ISSUE -> RESP -> IDLE. One transaction in flight; at most one transaction per 3 cycles.
//  - IDLE:
//    - If any req is high, latch the winner and its address/data into registers and go to ISSUE.
//    - Arbitration without the macro: fixed priority, data over fetch.
//  - ISSUE (1 cycle):
//    - Drive m_cs=1 from registers.
//    - Fetch winner: m_we=0, m_sel=0.
//    - Data winner: m_we=d_we, m_sel=1.
//    - The memory acts at the closing edge.
//  - RESP (1 cycle):
//    - Drive m_cs=0 and pulse the winner's ack.
//    - Fetch: f_inst=m_inst.
//    - Load: d_rdata=m_dat, d_err=0.
//    - Store: d_rdata=0, d_err=m_error.
//    - Then go to IDLE.
//  - Latency: ack is asserted 2 cycles after the edge at which IDLE sampled req. The requester drops req in the cycle after ack.
//  - Re-entry: a req still high in IDLE right after RESP is treated as a new request; requesters must deassert on ack.
//  - Simultaneous f_req and d_req in IDLE: one grant per arbitration rule. The loser waits with req held; it is not acked.
//  - Outputs between accesses: m_pc, m_addr and m_wdata hold their last values; m_cs=0 and m_we=0 outside ISSUE.
//  - f_inst and d_rdata hold their values until the next ack of the same port.
//  - Address widths pass through unchanged; no arithmetic is applied.
// CONFIGURATION
//  MEM_ARB_RR_EN
//    - Defined: round-robin between the two requesters on conflict. The grant pointer toggles to the other port after every granted transaction; an uncontested request is granted immediately regardless of the pointer.
//    - Undefined: data-over-fetch fixed priority; the pointer logic is not built.
// STRUCTURE
//  - Shared package/header mem_arb_pkg.vh:
//    - state encodings ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_RESP=2'd2
//    - grant encodings GNT_FETCH=1'b0, GNT_DATA=1'b1
//    - width macros reused from param.vh
//  - Sub-module: mem_arb_pick (combinational 2-way winner select, includes the RR pointer under the macro).
//  - FSM, request registers and response mux live in the top.
// TESTING
//  1 Reset: RESET=1 for 2 cycles mid-ISSUE -> all outputs 0, no ack, FSM in IDLE; next f_req is served normally.
//  2 Single fetch: f_req=1, f_pc=5, m_inst returns 32'h1234 -> m_cs=1/m_sel=0/m_pc=5 in ISSUE; f_ack with f_inst=32'h1234 2 cycles after sampling.
//  3 Store above ROM: d_we=1, d_addr=ROM_SIZE+3, d_wdata=7 -> m_we=1/m_sel=1 one cycle; d_ack with d_err=0; a later load of the same address returns 7.
//  4 Store into ROM: d_we=1, d_addr=0 -> d_ack with d_err=1; a load of address 0 returns the original contents.
//  5 Conflict: f_req and d_req high together for 6 transactions.
//    - Without macro: data served first every time.
//    - With MEM_ARB_RR_EN: grants alternate D,F,D,F...
//  6 Back-to-back loads to addresses 10, 11 -> two d_acks exactly 3 cycles apart with the correct m_dat values.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths, FSM and grant encodings for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam int ADDR_BITS = 16;
    localparam int DATA_BITS = 32;
    localparam int INST_BITS = 32;
    localparam int ROM_SIZE  = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signals of the arbiter
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic                 f_req;
    logic [ADDR_BITS-1:0] f_pc;
    logic                 f_ack;
    logic [INST_BITS-1:0] f_inst;

    logic                 d_req;
    logic                 d_we;
    logic [ADDR_BITS-1:0] d_addr;
    logic [DATA_BITS-1:0] d_wdata;
    logic                 d_ack;
    logic [INST_BITS-1:0] d_rdata;
    logic                 d_err;

    logic                 m_cs;
    logic                 m_we;
    logic                 m_sel;
    logic [ADDR_BITS-1:0] m_pc;
    logic [ADDR_BITS-1:0] m_addr;
    logic [DATA_BITS-1:0] m_wdata;
    logic [INST_BITS-1:0] m_inst;
    logic [INST_BITS-1:0] m_dat;
    logic                 m_error;

    // Arbiter side
    modport slave (
        input  f_req, f_pc, d_req, d_we, d_addr, d_wdata, m_inst, m_dat, m_error,
        output f_ack, f_inst, d_ack, d_rdata, d_err,
        output m_cs, m_we, m_sel, m_pc, m_addr, m_wdata
    );

    // Core pipeline plus memory side
    modport master (
        output f_req, f_pc, d_req, d_we, d_addr, d_wdata, m_inst, m_dat, m_error,
        input  f_ack, f_inst, d_ack, d_rdata, d_err,
        input  m_cs, m_we, m_sel, m_pc, m_addr, m_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - two-way winner select; MEM_ARB_RR_EN adds the round-robin pointer
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic advance,
`endif
    input  logic f_req,
    input  logic d_req,
    output logic any,
    output gnt_e gnt
);

`ifdef MEM_ARB_RR_EN
    gnt_e ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= GNT_DATA;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Pointer flips on every grant, contested or not
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (ptr_q == GNT_DATA) ? GNT_FETCH : GNT_DATA;
        end
    end

    always_comb begin
        any = f_req | d_req;
        if (f_req && d_req) begin
            gnt = ptr_q;
        end else if (d_req) begin
            gnt = GNT_DATA;
        end else begin
            gnt = GNT_FETCH;
        end
    end
`else
    always_comb begin
        any = f_req | d_req;
        gnt = d_req ? GNT_DATA : GNT_FETCH;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store; MEM_ARB_RR_EN selects round-robin
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    mem_port_arbiter_if.slave    bus
);

    arb_state_e           state_q, state_d;
    gnt_e                 gnt_q, gnt_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] pc_q, pc_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [INST_BITS-1:0] f_inst_q, f_inst_d;
    logic [INST_BITS-1:0] d_rdata_q, d_rdata_d;
    logic                 d_err_q, d_err_d;

    logic                 pick_any;
    gnt_e                 pick_gnt;

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .clk     (CLK),
        .reset   (RESET),
        .advance (state_q == ARB_IDLE && pick_any),
`endif
        .f_req   (bus.f_req),
        .d_req   (bus.d_req),
        .any     (pick_any),
        .gnt     (pick_gnt)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (pick_any) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = ARB_RESP;
            ARB_RESP:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            gnt_q     <= GNT_DATA;
            we_q      <= 1'b0;
            pc_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f_inst_q  <= '0;
            d_rdata_q <= '0;
            d_err_q   <= 1'b0;
        end else begin
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f_inst_q  <= f_inst_d;
            d_rdata_q <= d_rdata_d;
            d_err_q   <= d_err_d;
        end
    end

    // The *_d response values double as the ack-cycle outputs, so the
    // registered copies only need to carry them between acks.
    always_comb begin
        gnt_d     = gnt_q;
        we_d      = we_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        f_inst_d  = f_inst_q;
        d_rdata_d = d_rdata_q;
        d_err_d   = d_err_q;
        if (state_q == ARB_IDLE && pick_any) begin
            gnt_d = pick_gnt;
            if (pick_gnt == GNT_DATA) begin
                we_d    = bus.d_we;
                addr_d  = bus.d_addr;
                wdata_d = bus.d_wdata;
            end else begin
                we_d = 1'b0;
                pc_d = bus.f_pc;
            end
        end
        if (state_q == ARB_RESP) begin
            if (gnt_q == GNT_FETCH) begin
                f_inst_d = bus.m_inst;
            end else if (we_q) begin
                d_rdata_d = '0;
                d_err_d   = bus.m_error;
            end else begin
                d_rdata_d = bus.m_dat;
                d_err_d   = 1'b0;
            end
        end
    end

    always_comb begin
        bus.m_cs    = (state_q == ARB_ISSUE);
        bus.m_we    = (state_q == ARB_ISSUE) && we_q;
        bus.m_sel   = (state_q == ARB_ISSUE) && (gnt_q == GNT_DATA);
        bus.m_pc    = pc_q;
        bus.m_addr  = addr_q;
        bus.m_wdata = wdata_q;
        bus.f_ack   = (state_q == ARB_RESP) && (gnt_q == GNT_FETCH);
        bus.d_ack   = (state_q == ARB_RESP) && (gnt_q == GNT_DATA);
        bus.f_inst  = f_inst_d;
        bus.d_rdata = d_rdata_d;
        bus.d_err   = d_err_d;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a behavioural memory and reference model
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int IW = 2 + ADDR_BITS + DATA_BITS;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    mem_port_arbiter_if bus();

    mem_port_arbiter dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Memory environment: registered reads, stores below ROM_SIZE refused with an error
    logic [INST_BITS-1:0] tb_mem [0:63];
    logic [INST_BITS-1:0] mem_inst_q = '0;
    logic [INST_BITS-1:0] mem_dat_q = '0;
    logic                 mem_err_q = 1'b0;
    bit                   mem_loaded = 1'b0;
    assign bus.m_inst  = mem_inst_q;
    assign bus.m_dat   = mem_dat_q;
    assign bus.m_error = mem_err_q;

    function automatic logic [INST_BITS-1:0] init_word(input int i);
        if (i == 5) return 32'h1234;
        return (32'h9E3779B9 * (i + 1)) ^ 32'h0000_5A5A;
    endfunction

    always @(posedge CLK) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (bus.m_cs) begin
            if (!bus.m_sel) begin
                mem_inst_q <= tb_mem[bus.m_pc[5:0]];
            end else if (bus.m_we) begin
                if (bus.m_addr < ROM_SIZE) begin
                    mem_err_q <= 1'b1;
                end else begin
                    tb_mem[bus.m_addr[5:0]] <= bus.m_wdata;
                    mem_err_q <= 1'b0;
                end
            end else begin
                mem_dat_q <= tb_mem[bus.m_addr[5:0]];
                mem_err_q <= 1'b0;
            end
        end
    end

    // Reference model: memory image plus the values each port must hold between acks
    logic [INST_BITS-1:0] ref_mem [0:63];
    logic [INST_BITS-1:0] last_f = '0;
    logic [INST_BITS-1:0] last_d = '0;

    task automatic model(input int op, input logic [ADDR_BITS-1:0] addr, input logic [DATA_BITS-1:0] wdata,
                         output logic [INST_BITS-1:0] exp_rd, output logic exp_err);
        exp_err = 1'b0;
        if (op == 2) begin
            exp_rd = '0;
            exp_err = (addr < ROM_SIZE);
            if (!exp_err) ref_mem[addr[5:0]] = wdata;
            last_d = '0;
        end else begin
            exp_rd = ref_mem[addr[5:0]];
            if (op == 0) last_f = exp_rd;
            else last_d = exp_rd;
        end
    endtask

    // Drives one uncontested request from an IDLE negedge; returns what was observed
    task automatic txn(input bit is_data, input bit we, input logic [ADDR_BITS-1:0] addr,
                       input logic [DATA_BITS-1:0] wdata, output int lat, output int cs_cycles,
                       output logic [IW-1:0] iss, output logic [INST_BITS-1:0] rdata,
                       output logic err, output bit stray);
        lat = -1; cs_cycles = 0; iss = '0; rdata = '0; err = 1'b0; stray = 1'b0;
        if (is_data) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.f_req = 1'b1; bus.f_pc = addr;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            if (bus.m_cs) begin
                cs_cycles++;
                iss = {bus.m_we, bus.m_sel, (bus.m_sel ? bus.m_addr : bus.m_pc), bus.m_wdata};
            end else if (bus.m_we) begin
                stray = 1'b1;
            end
            if (is_data ? bus.f_ack : bus.d_ack) stray = 1'b1;
            if (is_data ? bus.d_ack : bus.f_ack) begin
                lat = c;
                rdata = is_data ? bus.d_rdata : bus.f_inst;
                err = is_data ? bus.d_err : 1'b0;
                break;
            end
        end
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [IW*2-1:0] outs;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        outs = '0;
        outs = {bus.f_ack, bus.f_inst, bus.d_ack, bus.d_rdata, bus.d_err, bus.m_cs, bus.m_we,
                bus.m_sel, bus.m_pc, bus.m_addr, bus.m_wdata};
        n_checks++;
        if (outs !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got=%h want=0", outs);
        end
        @(negedge CLK);
    endtask

    task automatic test_fetch();
        int lat, csn; logic [IW-1:0] iss; logic [INST_BITS-1:0] rd, erd; logic er, eer; bit stray;
        txn(1'b0, 1'b0, 16'd5, '0, lat, csn, iss, rd, er, stray);
        model(0, 16'd5, '0, erd, eer);
        n_checks++;
        if (lat !== 2 || csn !== 1 || stray) begin
            n_errors++;
            $display("FAIL fetch_timing lat=%0d cs=%0d stray=%0d want lat=2 cs=1 stray=0", lat, csn, stray);
        end
        n_checks++;
        if (iss[IW-1:DATA_BITS] !== {1'b0, 1'b0, 16'd5}) begin
            n_errors++;
            $display("FAIL fetch_issue got=%h want=%h", iss[IW-1:DATA_BITS], {1'b0, 1'b0, 16'd5});
        end
        n_checks++;
        if (rd !== 32'h1234) begin
            n_errors++;
            $display("FAIL fetch_data got=%h want=00001234", rd);
        end
    endtask

    task automatic test_store_above_rom();
        int lat, csn; logic [IW-1:0] iss; logic [INST_BITS-1:0] rd, erd; logic er, eer; bit stray;
        logic [ADDR_BITS-1:0] a;
        a = ADDR_BITS'(ROM_SIZE + 3);
        txn(1'b1, 1'b1, a, 32'd7, lat, csn, iss, rd, er, stray);
        model(2, a, 32'd7, erd, eer);
        n_checks++;
        if (lat !== 2 || csn !== 1 || stray) begin
            n_errors++;
            $display("FAIL store_timing lat=%0d cs=%0d stray=%0d want lat=2 cs=1 stray=0", lat, csn, stray);
        end
        n_checks++;
        if (iss !== {1'b1, 1'b1, a, 32'd7}) begin
            n_errors++;
            $display("FAIL store_issue got=%h want=%h", iss, {1'b1, 1'b1, a, 32'd7});
        end
        n_checks++;
        if (er !== 1'b0 || rd !== '0) begin
            n_errors++;
            $display("FAIL store_resp err=%0d rdata=%h want err=0 rdata=0", er, rd);
        end
        txn(1'b1, 1'b0, a, '0, lat, csn, iss, rd, er, stray);
        model(1, a, '0, erd, eer);
        n_checks++;
        if (rd !== 32'd7 || er !== 1'b0 || lat !== 2) begin
            n_errors++;
            $display("FAIL store_readback rdata=%h err=%0d lat=%0d want 7/0/2", rd, er, lat);
        end
    endtask

    task automatic test_store_rom();
        int lat, csn; logic [IW-1:0] iss; logic [INST_BITS-1:0] rd, erd; logic er, eer; bit stray;
        txn(1'b1, 1'b1, 16'd0, 32'hDEAD_BEEF, lat, csn, iss, rd, er, stray);
        model(2, 16'd0, 32'hDEAD_BEEF, erd, eer);
        n_checks++;
        if (er !== 1'b1 || lat !== 2) begin
            n_errors++;
            $display("FAIL rom_store err=%0d lat=%0d want err=1 lat=2", er, lat);
        end
        txn(1'b1, 1'b0, 16'd0, '0, lat, csn, iss, rd, er, stray);
        model(1, 16'd0, '0, erd, eer);
        n_checks++;
        if (rd !== init_word(0) || er !== 1'b0) begin
            n_errors++;
            $display("FAIL rom_readback rdata=%h err=%0d want %h/0", rd, er, init_word(0));
        end
    endtask

    task automatic test_reset_mid();
        int lat, csn; logic [IW-1:0] iss; logic [INST_BITS-1:0] rd, erd; logic er, eer; bit stray;
        logic [IW*2-1:0] outs;
        bit seen;
        bus.f_req = 1'b1; bus.f_pc = 16'd5;
        @(negedge CLK);
        n_checks++;
        if (bus.m_cs !== 1'b1 || bus.m_pc !== 16'd5) begin
            n_errors++;
            $display("FAIL rstmid_issue m_cs=%0d m_pc=%0d want 1/5", bus.m_cs, bus.m_pc);
        end
        RESET = 1'b1; bus.f_req = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            if (bus.f_ack || bus.d_ack) seen = 1'b1;
        end
        outs = '0;
        outs = {bus.f_ack, bus.f_inst, bus.d_ack, bus.d_rdata, bus.d_err, bus.m_cs, bus.m_we,
                bus.m_sel, bus.m_pc, bus.m_addr, bus.m_wdata};
        n_checks++;
        if (outs !== '0) begin
            n_errors++;
            $display("FAIL rstmid_outputs got=%h want=0", outs);
        end
        RESET = 1'b0;
        last_f = '0; last_d = '0;
        repeat (3) begin
            @(negedge CLK);
            if (bus.f_ack || bus.d_ack || bus.m_cs) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_errors++;
            $display("FAIL rstmid_no_ack got activity=1 want 0");
        end
        txn(1'b0, 1'b0, 16'd7, '0, lat, csn, iss, rd, er, stray);
        model(0, 16'd7, '0, erd, eer);
        n_checks++;
        if (rd !== erd || lat !== 2 || stray) begin
            n_errors++;
            $display("FAIL rstmid_fetch rdata=%h lat=%0d want %h/2", rd, lat, erd);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        logic [INST_BITS-1:0] r1, r2;
        t1 = -1; t2 = -1; r1 = '0; r2 = '0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'd10;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (bus.d_ack) begin
                if (t1 < 0) begin
                    t1 = cyc; r1 = bus.d_rdata; bus.d_addr = 16'd11;
                end else begin
                    t2 = cyc; r2 = bus.d_rdata;
                    break;
                end
            end
        end
        bus.d_req = 1'b0;
        @(negedge CLK);
        last_d = ref_mem[11];
        n_checks++;
        if (t1 < 0 || t2 < 0 || (t2 - t1) != 3) begin
            n_errors++;
            $display("FAIL b2b_spacing t1=%0d t2=%0d want 3 apart", t1, t2);
        end
        n_checks++;
        if (r1 !== ref_mem[10] || r2 !== ref_mem[11]) begin
            n_errors++;
            $display("FAIL b2b_data got=%h,%h want=%h,%h", r1, r2, ref_mem[10], ref_mem[11]);
        end
    endtask

    task automatic test_conflict();
        int got, pend;
        bit exp_d;
        logic [ADDR_BITS-1:0] pc, da;
        logic [1:0] acks;
        logic [INST_BITS-1:0] rdv, want;
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        last_f = '0; last_d = '0;
        pc = ADDR_BITS'($urandom_range(0, 63));
        da = ADDR_BITS'($urandom_range(0, 63));
        bus.f_req = 1'b1; bus.f_pc = pc;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = da;
        got = 0; pend = -1;
        for (int c = 0; c < 80 && got < 6; c++) begin
            @(negedge CLK);
            if (pend == 0) begin
                pc = ADDR_BITS'($urandom_range(0, 63)); bus.f_pc = pc; bus.f_req = 1'b1;
            end else if (pend == 1) begin
                da = ADDR_BITS'($urandom_range(0, 63)); bus.d_addr = da; bus.d_req = 1'b1;
            end
            pend = -1;
            if (bus.f_ack || bus.d_ack) begin
`ifdef MEM_ARB_RR_EN
                exp_d = (got % 2 == 0);
`else
                exp_d = 1'b1;
`endif
                acks = {bus.f_ack, bus.d_ack};
                rdv = bus.d_ack ? bus.d_rdata : bus.f_inst;
                want = bus.d_ack ? ref_mem[da[5:0]] : ref_mem[pc[5:0]];
                n_checks++;
                if (acks !== (exp_d ? 2'b01 : 2'b10)) begin
                    n_errors++;
                    $display("FAIL conflict_grant n=%0d acks(f,d)=%b want=%b", got, acks, exp_d ? 2'b01 : 2'b10);
                end
                n_checks++;
                if (rdv !== want) begin
                    n_errors++;
                    $display("FAIL conflict_data n=%0d got=%h want=%h", got, rdv, want);
                end
                if (bus.d_ack) begin
                    last_d = want; bus.d_req = 1'b0; pend = 1;
                end else begin
                    last_f = want; bus.f_req = 1'b0; pend = 0;
                end
                got++;
                if (got == 6) begin
                    bus.f_req = 1'b0; bus.d_req = 1'b0;
                end
            end
        end
        n_checks++;
        if (got != 6) begin
            n_errors++;
            $display("FAIL conflict_count got=%0d want=6", got);
        end
        bus.f_req = 1'b0; bus.d_req = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_random();
        int lat, csn, op; logic [IW-1:0] iss; logic [INST_BITS-1:0] rd, erd; logic er, eer; bit stray;
        logic [ADDR_BITS-1:0] a; logic [DATA_BITS-1:0] wd;
        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 2);
            a = ADDR_BITS'($urandom_range(0, 63));
            wd = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            txn(op != 0, op == 2, a, wd, lat, csn, iss, rd, er, stray);
            model(op, a, wd, erd, eer);
            n_checks++;
            if (lat !== 2 || csn !== 1 || stray) begin
                n_errors++;
                $display("FAIL rnd_timing k=%0d lat=%0d cs=%0d stray=%0d want 2/1/0", k, lat, csn, stray);
            end
            n_checks++;
            if (iss[IW-1:DATA_BITS] !== {op == 2, op != 0, a}) begin
                n_errors++;
                $display("FAIL rnd_issue k=%0d got=%h want=%h", k, iss[IW-1:DATA_BITS], {op == 2, op != 0, a});
            end
            if (op == 2) begin
                n_checks++;
                if (iss[DATA_BITS-1:0] !== wd) begin
                    n_errors++;
                    $display("FAIL rnd_wdata k=%0d got=%h want=%h", k, iss[DATA_BITS-1:0], wd);
                end
            end
            n_checks++;
            if (rd !== erd || er !== eer) begin
                n_errors++;
                $display("FAIL rnd_resp k=%0d op=%0d got=%h/%0d want=%h/%0d", k, op, rd, er, erd, eer);
            end
            n_checks++;
            if (bus.f_inst !== last_f || bus.d_rdata !== last_d) begin
                n_errors++;
                $display("FAIL rnd_hold k=%0d got=%h/%h want=%h/%h", k, bus.f_inst, bus.d_rdata, last_f, last_d);
            end
        end
    endtask

    initial begin
        bus.f_req = 1'b0; bus.f_pc = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_fetch();
        test_store_above_rom();
        test_store_rom();
        test_reset_mid();
        test_back_to_back();
        test_conflict();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
